// File: rtl/demux_pkg.sv
// ============================================================================
// demux_pkg : shared types and constants for the demux frame sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam logic [1:0] CH0 = 2'd0;
   localparam logic [1:0] CH1 = 2'd1;
   localparam logic [1:0] CH2 = 2'd2;
   localparam logic [1:0] CH3 = 2'd3;

   localparam int START_BITS = 1;

   // Counter width for a count range of n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/demux_frame_sequencer.sv
// ============================================================================
// demux_frame_sequencer : serialises a payload word as a framed bit stream
//                         (start bit, LSB-first data, idle gap) onto the
//                         1:4 demux data input while holding its selects.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module demux_frame_sequencer
   import demux_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_ch,
   input  logic [DATA_W-1:0] req_data,
   output logic              dmx_in,
   output logic              dmx_a,
   output logic              dmx_b,
   output logic              dmx_frame,
   output logic              done
);

   localparam int BW = cnt_width(DATA_W);
   localparam int GW = cnt_width(GAP_CYC);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              dmx_in_q, dmx_in_d;
   logic              dmx_a_q, dmx_a_d;
   logic              dmx_b_q, dmx_b_d;
   logic              dmx_frame_q, dmx_frame_d;
   logic              done_q, done_d;

   logic accept;
   logic bit_last;
   logic gap_last;

   assign accept   = req_valid && req_ready_q;
   assign bit_last = (bit_cnt_q == BIT_LAST);
   assign gap_last = (gap_cnt_q == GAP_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         req_ready_q <= 1'b1;
         dmx_in_q    <= 1'b0;
         dmx_a_q     <= 1'b0;
         dmx_b_q     <= 1'b0;
         dmx_frame_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         req_ready_q <= req_ready_d;
         dmx_in_q    <= dmx_in_d;
         dmx_a_q     <= dmx_a_d;
         dmx_b_q     <= dmx_b_d;
         dmx_frame_q <= dmx_frame_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept)   state_d = ST_START;
         ST_START:               state_d = ST_DATA;
         ST_DATA:  if (bit_last) state_d = ST_GAP;
         ST_GAP:   if (gap_last) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered, so each branch computes what the following
   // cycle must show, i.e. the values belonging to state_d.
   always_comb begin
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      dmx_a_d     = dmx_a_q;
      dmx_b_d     = dmx_b_q;
      req_ready_d = 1'b0;
      dmx_in_d    = 1'b0;
      dmx_frame_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (accept) begin
               shift_d     = req_data;
               dmx_a_d     = req_ch[1];
               dmx_b_d     = req_ch[0];
               bit_cnt_d   = '0;
               req_ready_d = 1'b0;
               dmx_in_d    = 1'b1;
               dmx_frame_d = 1'b1;
            end
         end
         ST_START: begin
            dmx_in_d    = shift_q[0];
            dmx_frame_d = 1'b1;
            shift_d     = shift_q >> 1;
            bit_cnt_d   = '0;
         end
         ST_DATA: begin
            if (bit_last) begin
               gap_cnt_d = '0;
               done_d    = (GAP_LAST == '0);
            end else begin
               bit_cnt_d   = bit_cnt_q + BW'(1);
               dmx_in_d    = shift_q[0];
               dmx_frame_d = 1'b1;
               shift_d     = shift_q >> 1;
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               gap_cnt_d   = '0;
               req_ready_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
               done_d    = (gap_cnt_d == GAP_LAST);
            end
         end
         default: begin
            req_ready_d = 1'b1;
         end
      endcase
   end

   assign req_ready = req_ready_q;
   assign dmx_in    = dmx_in_q;
   assign dmx_a     = dmx_a_q;
   assign dmx_b     = dmx_b_q;
   assign dmx_frame = dmx_frame_q;
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_frame_sequencer.sv
// ============================================================================
// tb_demux_frame_sequencer : checks two sequencer instances (8/2 and 1/1)
//                            against a frame-position reference model.
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_demux_frame_sequencer;
   import demux_pkg::*;

   localparam int W0 = 8;
   localparam int G0 = 2;
   localparam int W1 = 1;
   localparam int G1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v0, r0, i0, a0, b0, f0, dn0;
   logic [1:0] c0;
   logic [7:0] d0;
   logic       v1, r1, i1, a1, b1, f1, dn1;
   logic [1:0] c1;
   logic [0:0] d1;

   demux_frame_sequencer #(.DATA_W(W0), .GAP_CYC(G0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0), .req_ch(c0),
      .req_data(d0), .dmx_in(i0), .dmx_a(a0), .dmx_b(b0), .dmx_frame(f0), .done(dn0)
   );

   demux_frame_sequencer #(.DATA_W(W1), .GAP_CYC(G1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1), .req_ch(c1),
      .req_data(d1), .dmx_in(i1), .dmx_a(a1), .dmx_b(b1), .dmx_frame(f1), .done(dn1)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference: p = cycles since the accepting edge (0 = idle).
   int          p0 = 0, p1 = 0;
   logic [1:0]  s0 = '0, s1 = '0;
   logic [31:0] m0 = '0, m1 = '0;

   int hs0_k = 0, hs0_cnt = 0, done0_cnt = 0, done0_cyc = 0;
   int hs1_k = 0, hs1_cnt = 0, done1_cnt = 0, done1_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected {req_ready, dmx_in, dmx_a, dmx_b, dmx_frame, done} at frame position p.
   function automatic logic [5:0] exp_out(input int p, input int w, input int g,
                                           input logic [1:0] s, input logic [31:0] d);
      logic rdy, din, frm, dn;
      rdy = (p == 0);
      din = 1'b0;
      frm = 1'b0;
      if (p == 1) begin
         din = 1'b1;
         frm = 1'b1;
      end else if (p >= 2 && p <= w + 1) begin
         din = d[p-2];
         frm = 1'b1;
      end
      dn = (p == 1 + w + g);
      return {rdy, din, s[1], s[0], frm, dn};
   endfunction

   function automatic int next_pos(input int p, input int w, input int g, input logic v);
      if (p == 0)          return v ? 1 : 0;
      if (p == 1 + w + g)  return 0;
      return p + 1;
   endfunction

   task automatic tick();
      if (rst_n && v0 && r0) begin hs0_k = cyc; hs0_cnt++; end
      if (rst_n && v1 && r1) begin hs1_k = cyc; hs1_cnt++; end
      if (!rst_n) begin
         p0 = 0; s0 = '0; p1 = 0; s1 = '0;
      end else begin
         if (p0 == 0 && v0) begin s0 = c0; m0 = {24'b0, d0}; end
         if (p1 == 0 && v1) begin s1 = c1; m1 = {31'b0, d1}; end
         p0 = next_pos(p0, W0, G0, v0);
         p1 = next_pos(p1, W1, G1, v1);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("dut0_outs", {26'b0, r0, i0, a0, b0, f0, dn0}, {26'b0, exp_out(p0, W0, G0, s0, m0)});
      check("dut1_outs", {26'b0, r1, i1, a1, b1, f1, dn1}, {26'b0, exp_out(p1, W1, G1, s1, m1)});
      if (dn0) begin done0_cnt++; done0_cyc = cyc; end
      if (dn1) begin done1_cnt++; done1_cyc = cyc; end
   endtask

   initial begin
      int          base, first, dbase;
      logic [10:0] seq;
      logic [2:0]  seq1;
      logic [1:0]  prev_sel;

      // Reset held with a pending request on both instances.
      rst_n = 1'b0;
      v0 = 1'b1; c0 = 2'($urandom); d0 = 8'($urandom);
      v1 = 1'b1; c1 = 2'($urandom); d1 = 1'($urandom);
      @(negedge clk);
      repeat (3) tick();
      check("rst_vals", {26'b0, r0, i0, a0, b0, f0, dn0}, 32'h20);
      rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
      repeat (2) tick();
      check("rst_nocapture", hs0_cnt + hs1_cnt, 0);
      check("rst_idle_ready", {31'b0, r0}, 1);

      // Single frame ch2 / A5.
      c0 = CH2; d0 = 8'hA5; v0 = 1'b1;
      dbase = done0_cnt;
      seq = '0;
      for (int i = 0; i < 11; i++) begin
         tick();
         v0 = 1'b0;
         seq = {seq[9:0], i0};
      end
      check("single_bits", {21'b0, seq}, {21'b0, 11'b11010010100});
      check("single_sel", {30'b0, a0, b0}, {30'b0, CH2});
      check("single_done_cnt", done0_cnt - dbase, 1);
      check("single_done_cyc", done0_cyc - hs0_k, 11);
      tick();

      // Back-to-back: valid held high across two requests.
      base = hs0_cnt;
      c0 = CH0; d0 = 8'hFF; v0 = 1'b1;
      tick();
      first = hs0_k;
      c0 = CH3; d0 = 8'h00;
      prev_sel = {a0, b0};
      for (int i = 0; i < 20 && hs0_cnt < base + 2; i++) begin
         prev_sel = {a0, b0};
         tick();
      end
      v0 = 1'b0;
      check("b2b_accepts", hs0_cnt - base, 2);
      check("b2b_period", hs0_k - first, 12);
      check("b2b_sel_before", {30'b0, prev_sel}, {30'b0, CH0});
      check("b2b_sel_start", {30'b0, a0, b0}, {30'b0, CH3});
      repeat (12) tick();

      // Busy ignore: request pulse during DATA.
      c0 = CH2; d0 = 8'h5A; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      repeat (2) tick();
      base = hs0_cnt;
      c0 = CH1; d0 = 8'h3C; v0 = 1'b1;
      check("busy_ready", {31'b0, r0}, 0);
      tick();
      v0 = 1'b0;
      repeat (10) tick();
      check("busy_nocapture", hs0_cnt - base, 0);

      // Reset mid-DATA after payload bit 3.
      c0 = CH3; d0 = 8'($urandom); v0 = 1'b1;
      tick();
      v0 = 1'b0;
      repeat (4) tick();
      dbase = done0_cnt;
      rst_n = 1'b0;
      tick();
      check("midrst_vals", {26'b0, r0, i0, a0, b0, f0, dn0}, 32'h20);
      rst_n = 1'b1;
      repeat (12) tick();
      check("midrst_nodone", done0_cnt - dbase, 0);
      base = hs0_cnt;
      c0 = CH1; d0 = 8'($urandom); v0 = 1'b1;
      tick();
      v0 = 1'b0;
      check("midrst_accept", hs0_cnt - base, 1);
      check("midrst_sel", {30'b0, a0, b0}, {30'b0, CH1});
      repeat (11) tick();
      check("midrst_done", done0_cnt - dbase, 1);

      // DATA_W=1, GAP_CYC=1 instance: ch1 / 1'b1 with valid held.
      base = hs1_cnt;
      c1 = CH1; d1 = 1'b1; v1 = 1'b1;
      seq1 = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seq1 = {seq1[1:0], i1};
      end
      first = hs1_k;
      check("w1_bits", {29'b0, seq1}, {29'b0, 3'b110});
      check("w1_done_cyc", done1_cyc - first, 3);
      repeat (2) tick();
      v1 = 1'b0;
      check("w1_period", hs1_k - first, 4);
      check("w1_accepts", hs1_cnt - base, 2);
      repeat (4) tick();

      // Randomised traffic, honouring the hold-while-stalled requester rule.
      repeat (400) begin
         if (!v0 || r0) begin
            v0 = ($urandom % 3) == 0; c0 = 2'($urandom); d0 = 8'($urandom);
         end
         if (!v1 || r1) begin
            v1 = ($urandom % 2) == 0; c1 = 2'($urandom); d1 = 1'($urandom);
         end
         rst_n = ($urandom % 64) != 0;
         tick();
      end
      rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
      repeat (14) tick();
      check("final_idle", {30'b0, r0, r1}, 3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
